// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shift register; emits a registered word one cycle
// after its fourth byte is pushed.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            byte_idx_d = 2'd0;
            shift_d    = '0;
        end else if (push) begin
            // Shifting in from the top leaves the first byte in [7:0] after four pushes.
            shift_d    = {byte_in, shift_q[31:8]};
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                word_d       = {byte_in, shift_q[31:8]};
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx_q   <= 2'd0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign byte_idx   = byte_idx_q;
    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the core in reset until a verified program is in place.
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [3:0]  imem_be,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned WidxW = $clog2(MAX_WORDS + 1);

    loader_state_t    state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [WidxW-1:0] n_q, n_d;
    logic [WidxW-1:0] word_idx_q, word_idx_d;
    logic [7:0]       xor_q, xor_d;
    logic [31:0]      addr_q, addr_d;

    logic        xfer;
    logic        asm_clear;
    logic        asm_push;
    logic [1:0]  byte_idx;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] len;

    assign rx_ready = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);
    assign xfer     = rx_valid && rx_ready;
    assign len      = {rx_data, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        xor_d      = xor_q;
        addr_d     = addr_q;
        asm_clear  = 1'b0;
        asm_push   = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN0;
                    word_idx_d = '0;
                    xor_d      = '0;
                    asm_clear  = 1'b1;
                end
            end
            LEN0: begin
                if (xfer) begin
                    len_lo_d = rx_data;
                    xor_d    = xor_q ^ rx_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    xor_d = xor_q ^ rx_data;
                    if (32'(len) > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (len == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        n_d     = len[WidxW-1:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    xor_d    = xor_q ^ rx_data;
                    asm_push = 1'b1;
                    if (byte_idx == 2'd3) begin
                        // Address is registered alongside the assembled word so both land together.
                        addr_d     = BASE_ADDR + 32'({word_idx_q, 2'b00});
                        word_idx_d = word_idx_q + 1'b1;
                        if (word_idx_q == n_q - 1'b1) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == xor_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_lo_q   <= '0;
            n_q        <= '0;
            word_idx_q <= '0;
            xor_q      <= '0;
            addr_q     <= BASE_ADDR;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            xor_q      <= xor_d;
            addr_q     <= addr_d;
        end
    end

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .push       (asm_push),
        .byte_in    (rx_data),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word       (word)
    );

    assign imem_we    = word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = word;
    assign imem_be    = word_valid ? BE_WORD : 4'b0000;
    assign busy       = rx_ready;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign cpu_reset  = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, handshake gaps, checksum and
// length errors, and mid-frame reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [3:0]  imem_be;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_asrt = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int be_bad = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  frame[$];
    bit          rdy_drop;

    always #5 clk = ~clk;

    imem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_be    (imem_be),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Write monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_cnt++;
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (imem_be !== 4'hF) be_bad++;
        end else if (imem_be !== 4'h0) begin
            be_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        be_bad = 0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Presents one byte and waits (bounded) for it to transfer.
    task automatic send(input logic [7:0] b, input bit gap);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (rx_ready !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        if (rx_ready !== 1'b1) begin
            n_asrt++;
            n_fail++;
            $error("FAIL send_timeout: observed rx_ready %b expected 1", rx_ready);
        end else begin
            tick(1);
        end
        if (gap) begin
            rx_valid = 1'b0;
            tick(1);
        end
    endtask

    task automatic send_frame(input bit gap);
        rdy_drop = 1'b0;
        for (int i = 0; i < frame.size(); i++) begin
            send(frame[i], gap);
            if (i < frame.size() - 1 && !gap && rx_ready !== 1'b1) rdy_drop = 1'b1;
        end
        rx_valid = 1'b0;
        tick(2);
    endtask

    task automatic load_n2(input logic [7:0] csum);
        frame = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD, csum};
    endtask

    task automatic chk_n2_writes(input string tag);
        chk({tag, "_cnt"}, wr_cnt, 2);
        if (wr_cnt == 2) begin
            chk({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
            chk({tag, "_d0"}, wr_data[0], 32'h4433_2211);
            chk({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
            chk({tag, "_d1"}, wr_data[1], 32'hDDCC_BBAA);
        end
        chk({tag, "_be"}, be_bad, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset values
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_be", imem_be, 4'h0);

        // Single word; checksum 01^00^E3^A0^00^05 = 47
        clear_log();
        pulse_start();
        chk("t1_busy", busy, 1);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hE3, 1'b0);
        send(8'hA0, 1'b0);
        send(8'h00, 1'b0);
        send(8'h05, 1'b0);
        rx_valid = 1'b0;
        chk("t1_we_lat", imem_we, 1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_wdata", imem_wdata, 32'h0500_A0E3);
        chk("t1_be", imem_be, 4'hF);
        send(8'h47, 1'b0);
        rx_valid = 1'b0;
        tick(2);
        chk("t1_done", done, 1);
        chk("t1_cpu_reset", cpu_reset, 0);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_ready_low", rx_ready, 0);

        // N=2 back-to-back; checksum 46; start while busy is ignored
        clear_log();
        pulse_start();
        chk("t2_done_drop", done, 0);
        chk("t2_cpu_reset_rise", cpu_reset, 1);
        send(8'h02, 1'b0);
        rx_valid = 1'b0;
        pulse_start();
        chk("t2_start_ignored", busy, 1);
        frame = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
        send_frame(1'b0);
        chk("t2_ready_held", rdy_drop, 0);
        chk_n2_writes("t2");
        chk("t2_done", done, 1);

        // Same frame with rx_valid toggling
        clear_log();
        pulse_start();
        load_n2(8'h46);
        send_frame(1'b1);
        chk_n2_writes("t3");
        chk("t3_done", done, 1);
        chk("t3_error", error, 0);

        // Corrupted checksum, then recovery
        clear_log();
        pulse_start();
        load_n2(8'h47);
        send_frame(1'b0);
        chk("t4_error", error, 1);
        chk("t4_cpu_reset", cpu_reset, 1);
        chk("t4_done", done, 0);
        chk("t4_kept_writes", wr_cnt, 2);
        clear_log();
        pulse_start();
        chk("t4_error_clr", error, 0);
        load_n2(8'h46);
        send_frame(1'b0);
        chk("t4_done2", done, 1);
        chk("t4_error2", error, 0);
        chk_n2_writes("t4r");

        // Length 65 exceeds MAX_WORDS
        clear_log();
        pulse_start();
        send(8'h41, 1'b0);
        send(8'h00, 1'b0);
        rx_valid = 1'b0;
        chk("t5_err_now", error, 1);
        chk("t5_ready_low", rx_ready, 0);
        tick(3);
        chk("t5_no_write", wr_cnt, 0);

        // Zero-length program
        clear_log();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        chk("t5z_done", done, 1);
        chk("t5z_no_write", wr_cnt, 0);

        // Reset mid-word
        clear_log();
        pulse_start();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rx_valid = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("t6_no_write", wr_cnt, 0);
        chk("t6_cpu_reset", cpu_reset, 1);
        chk("t6_ready", rx_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_error", error, 0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_wdata", imem_wdata, 32'h0);
        pulse_start();
        load_n2(8'h46);
        send_frame(1'b0);
        chk_n2_writes("t6r");
        chk("t6_done2", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
